// File: rtl/riscv_datapath.sv
// rtl/riscv_datapath.sv - RV32I single-cycle datapath: PC, register file, immediate generator, ALU, writeback mux
module riscv_datapath #(
    parameter logic [31:0] INITIAL_PC = 32'h00400000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic [31:0] dReadData,
    input  logic        loadPC,
    input  logic        PCSrc,
    input  logic        ALUSrc,
    input  logic [3:0]  ALUCtrl,
    input  logic        RegWrite,
    input  logic        MemToReg,
    output logic [31:0] PC,
    output logic [31:0] dAddress,
    output logic [31:0] dWriteData,
    output logic [31:0] WriteBackData,
    output logic        Zero
);
    logic [31:0] r_regs [32];
    logic [31:0] r_pc;

    logic [4:0]  w_rs1_addr;
    logic [4:0]  w_rs2_addr;
    logic [4:0]  w_rd_addr;
    logic [31:0] w_rs1_data;
    logic [31:0] w_rs2_data;
    logic [31:0] w_imm;
    logic [31:0] w_branch_imm;
    logic [31:0] w_alu_b;
    logic [31:0] w_alu_result;
    logic [31:0] w_wb_data;
    logic        w_unused_funct3;

    assign w_rs1_addr = instr[19:15];
    assign w_rs2_addr = instr[24:20];
    assign w_rd_addr  = instr[11:7];

    // funct3 is decoded outside this block and only arrives here as ALUCtrl
    assign w_unused_funct3 = ^instr[14:12];

    assign w_rs1_data = (w_rs1_addr == 5'd0) ? 32'h0 : r_regs[w_rs1_addr];
    assign w_rs2_data = (w_rs2_addr == 5'd0) ? 32'h0 : r_regs[w_rs2_addr];

    assign w_branch_imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};

    always_comb begin
        w_imm = 32'h0;
        case (instr[6:0])
            7'b0000011,
            7'b0010011,
            7'b1100111: w_imm = {{20{instr[31]}}, instr[31:20]};
            7'b0100011: w_imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            7'b1100011: w_imm = w_branch_imm;
            default:    w_imm = 32'h0;
        endcase
    end

    assign w_alu_b = ALUSrc ? w_imm : w_rs2_data;

    always_comb begin
        w_alu_result = 32'h0;
        case (ALUCtrl)
            4'b0000: w_alu_result = w_rs1_data & w_alu_b;
            4'b0001: w_alu_result = w_rs1_data | w_alu_b;
            4'b0010: w_alu_result = w_rs1_data + w_alu_b;
            4'b0110: w_alu_result = w_rs1_data - w_alu_b;
            4'b0101: w_alu_result = w_rs1_data ^ w_alu_b;
            4'b0100: w_alu_result = {31'h0, ($signed(w_rs1_data) < $signed(w_alu_b))};
            4'b1001: w_alu_result = w_rs1_data << w_alu_b[4:0];
            4'b1000: w_alu_result = w_rs1_data >> w_alu_b[4:0];
            4'b1010: w_alu_result = $unsigned($signed(w_rs1_data) >>> w_alu_b[4:0]);
            default: w_alu_result = 32'h0;
        endcase
    end

    assign w_wb_data = MemToReg ? dReadData : w_alu_result;

    // Same-cycle reads see the pre-edge contents; there is deliberately no write bypass
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= 32'h0;
            end
        end else if (RegWrite && (w_rd_addr != 5'd0)) begin
            r_regs[w_rd_addr] <= w_wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= INITIAL_PC;
        end else if (loadPC) begin
            r_pc <= PCSrc ? (r_pc + w_branch_imm) : (r_pc + 32'd4);
        end
    end

    assign PC            = r_pc;
    assign dAddress      = w_alu_result;
    assign dWriteData    = w_rs2_data;
    assign WriteBackData = w_wb_data;
    assign Zero          = (w_alu_result == 32'h0);
endmodule

// File: tb/tb_riscv_datapath.sv
// tb/tb_riscv_datapath.sv - directed table, corner sequences and random checks of riscv_datapath against a reference model
module tb_riscv_datapath;
    localparam logic [31:0] INIT_PC = 32'h00400000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic [31:0] dReadData;
    logic        loadPC;
    logic        PCSrc;
    logic        ALUSrc;
    logic [3:0]  ALUCtrl;
    logic        RegWrite;
    logic        MemToReg;
    logic [31:0] PC;
    logic [31:0] dAddress;
    logic [31:0] dWriteData;
    logic [31:0] WriteBackData;
    logic        Zero;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_regs [32];
    logic [31:0] m_pc;

    riscv_datapath dut (
        .clk(clk), .rst(rst), .instr(instr), .dReadData(dReadData),
        .loadPC(loadPC), .PCSrc(PCSrc), .ALUSrc(ALUSrc), .ALUCtrl(ALUCtrl),
        .RegWrite(RegWrite), .MemToReg(MemToReg), .PC(PC), .dAddress(dAddress),
        .dWriteData(dWriteData), .WriteBackData(WriteBackData), .Zero(Zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic        alusrc;
        logic [3:0]  aluctrl;
        logic        regwrite;
        logic        memtoreg;
        logic [31:0] dread;
        logic [31:0] exp_alu;
        logic [31:0] exp_wb;
        logic [31:0] exp_wdata;
        logic        exp_zero;
    } vec_t;

    vec_t vecs [15];

    function automatic logic [31:0] m_imm(input logic [31:0] i);
        logic [11:0] s12;
        logic [12:0] b13;
        int v;
        v = 0;
        case (i[6:0])
            7'h03, 7'h13, 7'h67: begin s12 = i[31:20]; v = $signed(s12); end
            7'h23: begin s12 = {i[31:25], i[11:7]}; v = $signed(s12); end
            7'h63: begin b13 = {i[31], i[7], i[30:25], i[11:8], 1'b0}; v = $signed(b13); end
            default: v = 0;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] m_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0101: return a ^ b;
            4'b0100: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1001: return a << b[4:0];
            4'b1000: return a >> b[4:0];
            4'b1010: return 32'($signed(a) >>> b[4:0]);
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] m_rd(input logic [4:0] idx);
        return (idx == 5'd0) ? 32'd0 : m_regs[idx];
    endfunction

    function automatic logic [31:0] m_alu_now();
        logic [31:0] b;
        b = ALUSrc ? m_imm(instr) : m_rd(instr[24:20]);
        return m_alu(ALUCtrl, m_rd(instr[19:15]), b);
    endfunction

    function automatic logic [31:0] m_wb_now();
        return MemToReg ? dReadData : m_alu_now();
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic apply(input logic [31:0] ins, input logic asrc, input logic [3:0] actl,
                         input logic rw, input logic m2r, input logic [31:0] dr,
                         input logic lpc, input logic psrc, input logic r);
        instr = ins; ALUSrc = asrc; ALUCtrl = actl; RegWrite = rw; MemToReg = m2r;
        dReadData = dr; loadPC = lpc; PCSrc = psrc; rst = r;
        #2;
    endtask

    task automatic check_comb(input string tag);
        logic [31:0] alu;
        alu = m_alu_now();
        chk({tag, ".dAddress"}, dAddress, alu);
        chk({tag, ".dWriteData"}, dWriteData, m_rd(instr[24:20]));
        chk({tag, ".WriteBackData"}, WriteBackData, m_wb_now());
        chk({tag, ".Zero"}, {31'd0, Zero}, {31'd0, alu == 32'd0});
    endtask

    task automatic tick(input string tag);
        logic [31:0] wb;
        logic [31:0] bimm;
        wb = m_wb_now();
        bimm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        if (rst) begin
            m_pc = INIT_PC;
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        end else begin
            if (RegWrite && instr[11:7] != 5'd0) m_regs[instr[11:7]] = wb;
            if (loadPC) m_pc = m_pc + (PCSrc ? bimm : 32'd4);
        end
        @(posedge clk);
        #1;
        chk({tag, ".PC"}, PC, m_pc);
    endtask

    initial begin
        vecs[0]  = '{32'h00500093, 1'b1, 4'b0010, 1'b1, 1'b0, 32'h0, 32'd5,         32'd5,         32'd0,  1'b0};
        vecs[1]  = '{32'h40108133, 1'b0, 4'b0110, 1'b1, 1'b0, 32'h0, 32'd0,         32'd0,         32'd5,  1'b1};
        vecs[2]  = '{32'hFFF00193, 1'b1, 4'b0010, 1'b1, 1'b0, 32'h0, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'd0,  1'b0};
        vecs[3]  = '{32'h00100213, 1'b1, 4'b0010, 1'b1, 1'b0, 32'h0, 32'd1,         32'd1,         32'd5,  1'b0};
        vecs[4]  = '{32'h0041A2B3, 1'b0, 4'b0100, 1'b1, 1'b0, 32'h0, 32'd1,         32'd1,         32'd1,  1'b0};
        vecs[5]  = '{32'h00102423, 1'b1, 4'b0010, 1'b0, 1'b0, 32'h0, 32'd8,         32'd8,         32'd5,  1'b0};
        vecs[6]  = '{32'h00802183, 1'b1, 4'b0010, 1'b1, 1'b1, 32'hDEADBEEF, 32'd8,  32'hDEADBEEF,  32'd0,  1'b0};
        vecs[7]  = '{32'h00700013, 1'b1, 4'b0010, 1'b1, 1'b0, 32'h0, 32'd7,         32'd7,         32'd0,  1'b0};
        vecs[8]  = '{32'h00000333, 1'b0, 4'b0010, 1'b0, 1'b0, 32'h0, 32'd0,         32'd0,         32'd0,  1'b1};
        vecs[9]  = '{32'h0001E3B3, 1'b0, 4'b0001, 1'b0, 1'b0, 32'h0, 32'hDEADBEEF,  32'hDEADBEEF,  32'd0,  1'b0};
        vecs[10] = '{32'h00100413, 1'b1, 4'b0010, 1'b1, 1'b0, 32'h0, 32'd1,         32'd1,         32'd5,  1'b0};
        vecs[11] = '{32'h01F00493, 1'b1, 4'b0010, 1'b1, 1'b0, 32'h0, 32'd31,        32'd31,        32'd0,  1'b0};
        vecs[12] = '{32'h00941533, 1'b0, 4'b1001, 1'b1, 1'b0, 32'h0, 32'h80000000,  32'h80000000,  32'd31, 1'b0};
        vecs[13] = '{32'h409555B3, 1'b0, 4'b1010, 1'b0, 1'b0, 32'h0, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'd31, 1'b0};
        vecs[14] = '{32'h00955633, 1'b0, 4'b1000, 1'b0, 1'b0, 32'h0, 32'd1,         32'd1,         32'd31, 1'b0};

        for (int i = 0; i < 32; i++) m_regs[i] = 32'hX;
        m_pc = 32'hX;

        // Reset state
        apply(32'h00000013, 1'b0, 4'b0010, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        tick("reset");
        chk("reset.PC_value", PC, 32'h00400000);
        for (int i = 0; i < 32; i++) begin
            apply({7'd0, 5'(i), 5'(i), 3'b110, 5'd0, 7'h33}, 1'b0, 4'b0001, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
            chk($sformatf("reset.x%0d_rs1", i), dAddress, 32'd0);
            chk($sformatf("reset.x%0d_rs2", i), dWriteData, 32'd0);
        end
        apply(32'h00000033, 1'b0, 4'b0010, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("reset.add_dAddress", dAddress, 32'd0);
        chk("reset.add_Zero", {31'd0, Zero}, 32'd1);

        // Directed instruction table, PC held
        for (int i = 0; i < 15; i++) begin
            apply(vecs[i].instr, vecs[i].alusrc, vecs[i].aluctrl, vecs[i].regwrite, vecs[i].memtoreg,
                  vecs[i].dread, 1'b0, 1'b0, 1'b0);
            chk($sformatf("vec%0d.dAddress", i), dAddress, vecs[i].exp_alu);
            chk($sformatf("vec%0d.WriteBackData", i), WriteBackData, vecs[i].exp_wb);
            chk($sformatf("vec%0d.dWriteData", i), dWriteData, vecs[i].exp_wdata);
            chk($sformatf("vec%0d.Zero", i), {31'd0, Zero}, {31'd0, vecs[i].exp_zero});
            tick($sformatf("vec%0d", i));
        end
        chk("table.PC_held", PC, 32'h00400000);

        // PC sequencing: +4, branch back by -4, hold
        apply(32'h00000013, 1'b1, 4'b0010, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        tick("pc_plus4");
        chk("pc_plus4.value", PC, 32'h00400004);
        apply(32'hFE000EE3, 1'b0, 4'b0110, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        tick("pc_beq");
        chk("pc_beq.value", PC, 32'h00400000);
        apply(32'hFE000EE3, 1'b0, 4'b0110, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        tick("pc_hold");
        chk("pc_hold.value", PC, 32'h00400000);

        // No bypass: addi x1,x1,1 twice sees the old x1 each time
        apply(32'h00108093, 1'b1, 4'b0010, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("nobypass.first", WriteBackData, 32'd6);
        tick("nobypass1");
        chk("nobypass.second", WriteBackData, 32'd7);
        tick("nobypass2");

        // Reset mid-sequence overrides pending PC and register writes
        apply(32'h00500093, 1'b1, 4'b0010, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        tick("midreset");
        chk("midreset.PC", PC, 32'h00400000);
        apply(32'h0000E3B3 | (32'd1 << 15) | (32'd3 << 20), 1'b0, 4'b0001, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("midreset.x1", dAddress, 32'd0);
        chk("midreset.x3", dWriteData, 32'd0);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            logic [31:0] ri;
            logic [6:0]  ops [7];
            logic        psrc;
            ops = '{7'h03, 7'h13, 7'h23, 7'h63, 7'h33, 7'h67, 7'h37};
            ri = $urandom;
            ri[6:0] = ops[$urandom_range(0, 6)];
            psrc = 1'($urandom);
            if (psrc) ri[6:0] = 7'h63;
            apply(ri, 1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), $urandom,
                  1'($urandom), psrc, ($urandom_range(0, 39) == 0));
            check_comb($sformatf("rand%0d", n));
            tick($sformatf("rand%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/riscv_datapath.md
RISCV_DATAPATH -- requirements
Module: riscv_datapath

Interface
REQ-001 The block SHALL have parameter INITIAL_PC, default 32'h00400000, which is the PC value loaded on reset.
REQ-002 The block SHALL have port clk, input, 1 bit: the clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-004 The block SHALL have port instr, input, 32 bits: the current RV32I instruction word.
REQ-005 The block SHALL have port dReadData, input, 32 bits: load data returned by data memory.
REQ-006 The block SHALL have port loadPC, input, 1 bit: PC update enable.
REQ-007 The block SHALL have port PCSrc, input, 1 bit: 1 selects the branch target, 0 selects PC+4.
REQ-008 The block SHALL have port ALUSrc, input, 1 bit: 1 selects the immediate as ALU operand B, 0 selects rs2 data.
REQ-009 The block SHALL have port ALUCtrl, input, 4 bits: ALU operation select.
REQ-010 The block SHALL have port RegWrite, input, 1 bit: register-file write enable.
REQ-011 The block SHALL have port MemToReg, input, 1 bit: 1 selects dReadData for writeback, 0 selects the ALU result.
REQ-012 The block SHALL have port PC, output, 32 bits: the program counter register.
REQ-013 The block SHALL have port dAddress, output, 32 bits: data memory address, equal to the ALU result.
REQ-014 The block SHALL have port dWriteData, output, 32 bits: store data, equal to the rs2 read data.
REQ-015 The block SHALL have port WriteBackData, output, 32 bits: the writeback mux output.
REQ-016 The block SHALL have port Zero, output, 1 bit: 1 when the ALU result equals 32'h0.

Function
REQ-017 Register file: 32 x 32-bit; combinational reads at rs1=instr[19:15] and rs2=instr[24:20]; x0 always reads 0.
REQ-018 Register write: on a rising clk edge with RegWrite=1, reg[instr[11:7]] <= WriteBackData; writes to x0 are ignored.
REQ-019 A read of the register being written in the same cycle SHALL return the old value (no bypass).
REQ-020 Immediate generation, by opcode instr[6:0]:
- 0000011/0010011/1100111: sext(instr[31:20]).
- 0100011: sext({instr[31:25],instr[11:7]}).
- 1100011: sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}).
- All other opcodes: 0.
REQ-021 ALU operands: A=rs1 data; B=ALUSrc ? imm : rs2 data.
REQ-022 ALU operations, all 32-bit with wrap-around and no overflow flag:
- 0000 AND; 0001 OR; 0010 ADD; 0110 SUB (A-B); 0101 XOR.
- 0100 SLT: signed A<B gives 1, else 0.
- 1001 SLL, 1000 SRL, 1010 SRA, each by B[4:0].
- All other codes: result 0.
REQ-023 Zero, dAddress, dWriteData and WriteBackData SHALL be purely combinational from the current inputs and state.
REQ-024 PC update on a rising clk edge with loadPC=1:
- PCSrc=1: PC <= PC + imm, where imm is the branch immediate of the current instr.
- PCSrc=0: PC <= PC + 4.
- All additions modulo 2^32.
REQ-025 With loadPC=0, PC SHALL hold its value.
REQ-026 The block SHALL NOT check PC alignment.

Reset
REQ-027 When rst=1 at a rising edge: PC <= INITIAL_PC and all 32 registers <= 0; rst overrides loadPC and RegWrite in that cycle.
REQ-028 Reset applied mid-sequence SHALL discard any pending update; from the next cycle, outputs follow REQ-013 to REQ-016 with all registers at 0.

Verification
REQ-029 Reset: hold rst=1 for 1 cycle -> PC=32'h00400000; every register reads 0; with ALUCtrl=0010 and ALUSrc=0, dAddress=0 and Zero=1.
REQ-030 Immediate add: apply instr=addi x1,x0,5 (32'h00500093), ALUSrc=1, ALUCtrl=0010, RegWrite=1 for one edge -> x1=5 and WriteBackData=5 before the edge.
REQ-031 Subtract: with x1=5, apply sub x2,x1,x1 using ALUCtrl=0110, ALUSrc=0 -> Zero=1 and x2=0; with SLT on x1=-1 and x2=1 -> result 1.
REQ-032 Load/store: apply sw x1,8(x0) -> dAddress=8 and dWriteData=x1; apply lw x3,8(x0) with MemToReg=1 and dReadData=32'hDEADBEEF -> x3=32'hDEADBEEF.
REQ-033 PC: at PC=32'h00400000, one edge with loadPC=1 and PCSrc=0 -> PC=32'h00400004; then beq with offset -4, PCSrc=1, loadPC=1 -> PC=32'h00400000; with loadPC=0 -> PC unchanged.
REQ-034 Register-file boundaries: a write to x0 leaves x0 at 0; SRA of 32'h80000000 by 31 -> 32'hFFFFFFFF; SRL of the same value by 31 -> 1.
